instruction_encoder: RTL
========================

# instruction_encoder

Packs instruction fields (opcode, base register, destination register, 16-bit immediate) into 32-bit instruction words and writes them sequentially into instruction memory. It sits between the program-load source (host link or test sequencer) and the instruction RAM, and produces exactly the word format the processor's decode stage splits apart. One load session writes `length` consecutive words starting at `base_addr`, with a valid/ready field interface and one registered write stage.

## Interface
Parameters:
- `ADDR_W`, 8: instruction-memory address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begins a load session; sampled only in IDLE.
- `base_addr` in ADDR_W: first write address; sampled with `start`.
- `length` in ADDR_W: number of words to write; sampled with `start`.
- `in_valid` in 1: field tuple valid.
- `in_ready` out 1: encoder can accept a tuple.
- `opcode` in 6, `r1` in 5, `r2` in 5, `immediate` in 16: instruction fields.
- `mem_we` out 1: instruction-RAM write strobe.
- `mem_addr` out ADDR_W: write address.
- `mem_wdata` out 32: packed word.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse at the end of a session.
- `count` out ADDR_W: words written in the current or last session.
- `checksum` out 32: present only with `ENCODER_CHECKSUM_EN`.

## Operation
- Packing: `mem_wdata = {opcode, r1, r2, immediate}`. Bits [31:26]=opcode, [25:21]=r1, [20:16]=r2, [15:0]=immediate. No field is altered or checked.
- FSM states: IDLE, LOAD, DONE.
  - IDLE to LOAD: on `start` with `length` != 0. The block latches `base_addr` into the address counter and `length` into the remaining counter, and clears `count`.
  - IDLE to DONE: on `start` with `length` == 0. No write occurs.
  - LOAD to DONE: on the handshake that takes remaining to 0.
  - DONE to IDLE: unconditionally after one cycle.
- `in_ready` = (state == LOAD) && (remaining != 0).
- A handshake is `in_valid && in_ready`. On each handshake the block registers the packed word and the current address into the write stage, increments the address and `count`, and decrements remaining.
- The address wraps modulo 2^ADDR_W; base 0xFF with length 2 writes 0xFF then 0x00.
- `start` during LOAD or DONE is ignored.
- `in_valid` outside LOAD is ignored: nothing is stored and no write occurs.
- `reset` at any time forces IDLE. It clears all counters and the write stage, and suppresses any pending write.
- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `count`=0, `checksum`=0.

## Timing
- A `start` at cycle 0 puts the block in LOAD at cycle 1, with `in_ready` high from cycle 1.
- Latency: a handshake at cycle n produces `mem_we`=1 at cycle n+1, with that tuple's address and data. Throughput is one word per cycle.
- After the final handshake at cycle n: `done`=1 at n+1 (same cycle as the last `mem_we`), `busy`=0 at n+2.
- For `length`=0: `start` at cycle 0 gives `done`=1 at cycle 1, `busy`=0 at cycle 2, and no `mem_we`.
- `mem_we` is high for exactly one cycle per handshake. `mem_addr` and `mem_wdata` hold their values when `mem_we`=0.
- `count` is updated in the cycle the handshake registers. It holds its value through IDLE until the next `start`.

## Configuration
- `ENCODER_CHECKSUM_EN` defined:
  - The `checksum` port exists. It is cleared on an accepted `start` and updated as `checksum ^= mem_wdata` in the cycle of each write (visible one cycle after `mem_we`).
  - The final value is stable from the cycle after `done`.
- Not defined: no `checksum` port and no checksum register. All other behaviour is identical.

## Structure
- Shared package holds:
  - Field widths: OPCODE_W=6, REG_W=5, IMM_W=16, INSTR_W=32.
  - Field bit positions: OPCODE_LSB=26, R1_LSB=21, R2_LSB=16.
  - The FSM state enum.
- The decode stage uses the same constants, so the encoder and decoder cannot drift apart.
- One natural sub-module, `instr_pack`: a purely combinational field-to-word packer, reused by test benches to build expected words.

## Test plan
- Basic load: `base_addr`=0x10, `length`=3, tuples (0x23,1,2,0x0004), (0x2B,3,4,0xFFFC), (0x00,0,0,0) sent back-to-back -> writes 0x10:0x8C220004, 0x11:0xAC64FFFC, 0x12:0x00000000 on consecutive cycles; `done` with the third write; `count`=3.
- Backpressure gaps: same load with `in_valid` low every other cycle -> identical words and addresses, no `mem_we` in gap cycles.
- Wrap and zero length:
  - `base_addr`=0xFF, `length`=2 -> writes at 0xFF then 0x00.
  - `length`=0 -> `done` one cycle after `start`, no writes.
- Ignored inputs: `start` pulsed mid-session and `in_valid` asserted while IDLE -> no effect on address, `count`, or writes.
- Reset mid-load: `reset` in the cycle after the 2nd of 4 handshakes -> no further `mem_we`; all outputs at reset values next cycle; `in_ready`=0.
- With `ENCODER_CHECKSUM_EN`: basic-load words -> `checksum` = 0x8C220004 ^ 0xAC64FFFC = 0x2046FFF8.

Source files
------------

// File: rtl/instruction_encoder_pkg.sv
// Shared instruction-word layout and encoder FSM states, also used by the decode stage.
package instruction_encoder_pkg;

  localparam int OPCODE_W   = 6;
  localparam int REG_W      = 5;
  localparam int IMM_W      = 16;
  localparam int INSTR_W    = 32;

  localparam int OPCODE_LSB = 26;
  localparam int R1_LSB     = 21;
  localparam int R2_LSB     = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    STATE_IDLE = ST_IDLE,
    STATE_LOAD = ST_LOAD,
    STATE_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/instruction_encoder_instr_pack.sv
// Combinational field-to-word packer; bit placement comes only from the shared package.
module instr_pack
  import instruction_encoder_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [REG_W-1:0]    r1,
  input  logic [REG_W-1:0]    r2,
  input  logic [IMM_W-1:0]    immediate,
  output logic [INSTR_W-1:0]  word
);

  // Place each field at its package-defined bit position
  always_comb begin
    word                        = {INSTR_W{1'b0}};
    word[OPCODE_LSB +: OPCODE_W] = opcode;
    word[R1_LSB +: REG_W]        = r1;
    word[R2_LSB +: REG_W]        = r2;
    word[0 +: IMM_W]             = immediate;
  end

endmodule

// File: rtl/instruction_encoder.sv
// Packs field tuples into instruction words and writes a session of them to instruction RAM.
// Optional feature: define ENCODER_CHECKSUM_EN to add the running XOR checksum output.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   length,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [REG_W-1:0]    r1,
  input  logic [REG_W-1:0]    r2,
  input  logic [IMM_W-1:0]    immediate,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [INSTR_W-1:0]  mem_wdata,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   count
`ifdef ENCODER_CHECKSUM_EN
  ,
  output logic [INSTR_W-1:0]  checksum
`endif
);

  state_e              state_r;
  state_e              state_nx_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W-1:0]   remaining_r;
  logic [ADDR_W-1:0]   count_r;
  logic                we_r;
  logic [ADDR_W-1:0]   waddr_r;
  logic [INSTR_W-1:0]  wdata_r;
  logic [INSTR_W-1:0]  packed_s;
  logic                in_ready_s;
  logic                handshake_s;
  logic                accept_start_s;

  instr_pack u_pack (
    .opcode    (opcode),
    .r1        (r1),
    .r2        (r2),
    .immediate (immediate),
    .word      (packed_s)
  );

  assign in_ready_s     = (state_r == STATE_LOAD) && (remaining_r != {ADDR_W{1'b0}});
  assign handshake_s    = in_valid && in_ready_s;
  assign accept_start_s = (state_r == STATE_IDLE) && start;

  // Next-state decode; a zero-length session goes straight to DONE
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      STATE_IDLE: begin
        if (start) begin
          state_nx_s = (length == {ADDR_W{1'b0}}) ? STATE_DONE : STATE_LOAD;
        end else begin
          state_nx_s = STATE_IDLE;
        end
      end
      STATE_LOAD: begin
        if (handshake_s && (remaining_r == ADDR_W'(1))) begin
          state_nx_s = STATE_DONE;
        end else begin
          state_nx_s = STATE_LOAD;
        end
      end
      STATE_DONE: state_nx_s = STATE_IDLE;
      default:    state_nx_s = STATE_IDLE;
    endcase
  end

  // FSM, session counters and the registered write stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= STATE_IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      remaining_r <= {ADDR_W{1'b0}};
      count_r     <= {ADDR_W{1'b0}};
      we_r        <= 1'b0;
      waddr_r     <= {ADDR_W{1'b0}};
      wdata_r     <= {INSTR_W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      we_r    <= handshake_s;
      if (accept_start_s) begin
        addr_r      <= base_addr;
        remaining_r <= length;
        count_r     <= {ADDR_W{1'b0}};
      end else if (handshake_s) begin
        // Address wraps naturally at 2^ADDR_W
        waddr_r     <= addr_r;
        wdata_r     <= packed_s;
        addr_r      <= addr_r + ADDR_W'(1);
        count_r     <= count_r + ADDR_W'(1);
        remaining_r <= remaining_r - ADDR_W'(1);
      end
    end
  end

`ifdef ENCODER_CHECKSUM_EN
  logic [INSTR_W-1:0] checksum_r;

  // Running XOR of written words, folded in on the cycle each write is presented
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_r <= {INSTR_W{1'b0}};
    end else if (accept_start_s) begin
      checksum_r <= {INSTR_W{1'b0}};
    end else if (we_r) begin
      checksum_r <= checksum_r ^ wdata_r;
    end
  end

  assign checksum = checksum_r;
`endif

  assign in_ready  = in_ready_s;
  assign mem_we    = we_r;
  assign mem_addr  = waddr_r;
  assign mem_wdata = wdata_r;
  assign busy      = (state_r != STATE_IDLE);
  assign done      = (state_r == STATE_DONE);
  assign count     = count_r;

endmodule
